// File: rtl/beep_pkg.sv
// Shared definitions for the melody sequencer: note codes, FSM states and
// the layout of a 6-bit melody entry.
package beep_pkg;

    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int ENTRY_W  = 6;
    localparam int LAST_BIT = 5;
    localparam int DUR_LSB  = 3;
    localparam int DUR_W    = 2;
    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 3;
    localparam int PERIOD_W = 18;

    typedef enum logic [NOTE_W-1:0] {
        REST = 3'd0,
        DO   = 3'd1,
        RI   = 3'd2,
        MI   = 3'd3,
        FA   = 3'd4,
        SO   = 3'd5,
        LA   = 3'd6,
        XI   = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic entry_last(input logic [ENTRY_W-1:0] e);
        return e[LAST_BIT];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_LSB +: DUR_W];
    endfunction

    function automatic note_t entry_note(input logic [ENTRY_W-1:0] e);
        return note_t'(e[NOTE_LSB +: NOTE_W]);
    endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// Control, melody-write and status signals of the beep sequencer.
interface beep_sequencer_if;

    logic                         start;
    logic                         stop;
    logic                         pause;
    logic                         loop_en;
    logic                         wr_en;
    logic [beep_pkg::ADDR_W-1:0]  wr_addr;
    logic [beep_pkg::ENTRY_W-1:0] wr_data;
    logic                         beep;
    logic                         busy;
    logic                         done;
    logic [beep_pkg::ADDR_W-1:0]  note_idx;

    modport master (
        output start, stop, pause, loop_en, wr_en, wr_addr, wr_data,
        input  beep, busy, done, note_idx
    );

    modport slave (
        input  start, stop, pause, loop_en, wr_en, wr_addr, wr_data,
        output beep, busy, done, note_idx
    );

endinterface

// File: rtl/beep_tone_gen.sv
// Square-wave generator: counts 0..period-1 while enabled and drives high
// for the first floor(period/2) counts. rst doubles as the phase restart.
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                beep
);

    logic [PERIOD_W-1:0] cnt_reg;
    logic [PERIOD_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en && (period != '0)) begin
            cnt_next = (cnt_reg >= period - 1'b1) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign beep = (cnt_reg < (period >> 1));

endmodule

// File: rtl/beep_sequencer.sv
// Melody player: steps through a 16-entry note RAM, holding each note for
// its duration, inserting an optional silent gap, with pause/stop/loop.
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int time_unit  = 12_500_000,
    parameter int gap_cycles = 2_500_000,
    parameter int Do_freq    = 191_110,
    parameter int Ri_freq    = 170_262,
    parameter int Mi_freq    = 151_686,
    parameter int Fa_freq    = 143_173,
    parameter int So_freq    = 127_551,
    parameter int La_freq    = 113_636,
    parameter int Xi_freq    = 101_239
) (
    input  logic             clk,
    input  logic             rst,
    beep_sequencer_if.slave  bus
);

    localparam int DUR_CW  = $clog2(4 * time_unit);
    localparam int GAP_CW  = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
    localparam bit HAS_GAP = (gap_cycles > 0);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(HAS_GAP ? gap_cycles - 1 : 0);
    localparam int FREQS [8] = '{0, Do_freq, Ri_freq, Mi_freq, Fa_freq,
                                 So_freq, La_freq, Xi_freq};

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [DUR_CW-1:0]   dur_cnt_reg, dur_cnt_next;
    logic [GAP_CW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic                load_note;
    logic                advance;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  cur_entry;
    note_t               cur_note;
    logic [DUR_W-1:0]    cur_dur;
    logic [DUR_CW-1:0]   dur_last;
    logic                end_of_melody;

    logic [PERIOD_W-1:0] period_tab [8];
    logic [PERIOD_W-1:0] cur_period;
    logic                tone_en;
    logic                tone_rst;
    logic                tone_beep;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : gen_period
            assign period_tab[gi] = PERIOD_W'(FREQS[gi]);
        end
    endgenerate

    // RAM is left out of reset so a melody survives rst.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_reg == IDLE)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign cur_entry     = mem[idx_reg];
    assign cur_note      = entry_note(cur_entry);
    assign cur_dur       = entry_dur(cur_entry);
    assign cur_period    = period_tab[cur_note];
    assign end_of_melody = entry_last(cur_entry) || (idx_reg == ADDR_W'(DEPTH - 1));
    assign dur_last      = DUR_CW'((32'(cur_dur) + 32'd1) * 32'(time_unit) - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            dur_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            dur_cnt_reg <= dur_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        dur_cnt_next = dur_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        load_note    = 1'b0;
        advance      = 1'b0;

        if (bus.stop) begin
            state_next   = IDLE;
            idx_next     = '0;
            dur_cnt_next = '0;
            gap_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.pause) begin
                        state_next   = PLAY;
                        idx_next     = '0;
                        dur_cnt_next = '0;
                        load_note    = 1'b1;
                    end
                end
                PLAY: begin
                    if (!bus.pause) begin
                        if (dur_cnt_reg == dur_last) begin
                            dur_cnt_next = '0;
                            if (HAS_GAP) begin
                                state_next   = GAP;
                                gap_cnt_next = '0;
                            end else begin
                                advance = 1'b1;
                            end
                        end else begin
                            dur_cnt_next = dur_cnt_reg + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (!bus.pause) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            gap_cnt_next = '0;
                            advance      = 1'b1;
                        end else begin
                            gap_cnt_next = gap_cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // Leaving a note: next entry, wrap, or finish.
            if (advance) begin
                if (end_of_melody) begin
                    if (bus.loop_en) begin
                        state_next = PLAY;
                        idx_next   = '0;
                        load_note  = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = PLAY;
                    idx_next   = idx_reg + 1'b1;
                    load_note  = 1'b1;
                end
            end
        end
    end

    assign tone_en  = (state_reg == PLAY) && !bus.pause && !bus.stop;
    assign tone_rst = rst || load_note;

    beep_tone_gen u_tone (
        .clk    (clk),
        .rst    (tone_rst),
        .en     (tone_en),
        .period (cur_period),
        .beep   (tone_beep)
    );

    assign bus.beep     = tone_en && (cur_note != REST) && tone_beep;
    assign bus.busy     = (state_reg == PLAY) || (state_reg == GAP);
    assign bus.done     = (state_reg == DONE);
    assign bus.note_idx = idx_reg;

endmodule
